sysbus_mem_responder: RTL

Responder end of the Sysbus: a behavioural line-granular memory that sits on the `Bottom` side of the bus in simulation benches, in place of the external memory model. It accepts read and write transactions from the `MemArbiter`/core initiator side, stores 64-byte lines, and returns read lines as `BEATS` tagged response beats. It allows a single outstanding transaction and uses fully synchronous handshakes.

---
 rtl/sysbus_pkg.sv | 24 ++
 rtl/sysbus_line_store.sv | 26 ++
 rtl/sysbus_mem_responder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sysbus_pkg.sv
// Shared types and helpers for the Sysbus memory responder.
// The responder FSM states, the tag read/write field and the line-index helper live here.
package sysbus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    WAIT  = 2'd2,
    RDATA = 2'd3
  } state_e;

  // Read/write flag is the tag MSB; this is its position for the default 13-bit tag.
  localparam int   TAG_RW_BIT = 12;
  localparam logic TAG_READ   = 1'b1;

  function automatic logic [63:0] lineIndex(input logic [63:0] addr,
                                            input int          offBits,
                                            input int          lineBits);
    logic [63:0] mask;
    mask = (64'd1 << lineBits) - 64'd1;
    return (addr >> offBits) & mask;
  endfunction

endpackage

// File: rtl/sysbus_line_store.sv
// Line-granular storage: LINES x BEATS words, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module sysbus_line_store #(
  parameter int DATA_WIDTH = 64,
  parameter int LINES      = 256,
  parameter int BEATS      = 8
) (
  input  logic                       clk,
  input  logic                       wrEn_i,
  input  logic [$clog2(LINES)-1:0]   wrLine_i,
  input  logic [$clog2(BEATS)-1:0]   wrBeat_i,
  input  logic [DATA_WIDTH-1:0]      wrData_i,
  input  logic [$clog2(LINES)-1:0]   rdLine_i,
  input  logic [$clog2(BEATS)-1:0]   rdBeat_i,
  output logic [DATA_WIDTH-1:0]      rdData_o
);

  logic [DATA_WIDTH-1:0] memQ [LINES*BEATS];

  always_ff @(posedge clk) begin
    if (wrEn_i) memQ[{wrLine_i, wrBeat_i}] <= wrData_i;
  end

  assign rdData_o = memQ[{rdLine_i, rdBeat_i}];

endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus responder acting as a behavioural line memory: one outstanding transaction,
// writes absorb BEATS data beats, reads return BEATS tagged beats after LATENCY cycles.
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13,
  parameter int LINES      = 256,
  parameter int BEATS      = 8,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] req,
  input  logic [TAG_WIDTH-1:0]  reqtag,
  input  logic                  reqcyc,
  output logic                  reqack,
  output logic [DATA_WIDTH-1:0] resp,
  output logic [TAG_WIDTH-1:0]  resptag,
  output logic                  respcyc,
  input  logic                  respack
);

  localparam int OFF_W  = $clog2(BEATS*DATA_WIDTH/8);
  localparam int LINE_W = $clog2(LINES);
  localparam int BEAT_W = $clog2(BEATS);
  localparam int CNT_W  = $clog2(LATENCY+1);

  state_e             stateQ, stateD;
  logic [LINE_W-1:0]  lineQ, lineD;
  logic [TAG_WIDTH-1:0] tagQ, tagD;
  logic [BEAT_W-1:0]  beatQ, beatD;
  logic [CNT_W-1:0]   cntQ, cntD;
  logic               wrEn;
  logic [DATA_WIDTH-1:0] rdData;
  logic               lastBeat;

  assign lastBeat = (beatQ == BEAT_W'(BEATS-1));

  always_comb begin
    stateD = stateQ;
    lineD  = lineQ;
    tagD   = tagQ;
    beatD  = beatQ;
    cntD   = cntQ;
    reqack = 1'b0;
    wrEn   = 1'b0;
    unique case (stateQ)
      IDLE: begin
        reqack = reqcyc;
        if (reqcyc) begin
          lineD = LINE_W'(lineIndex(64'(req), OFF_W, LINE_W));
          tagD  = reqtag;
          beatD = '0;
          if (reqtag[TAG_WIDTH-1] == TAG_READ) begin
            cntD   = CNT_W'(LATENCY-1);
            stateD = (LATENCY == 1) ? RDATA : WAIT;
          end else begin
            stateD = WDATA;
          end
        end
      end
      WDATA: begin
        reqack = reqcyc;
        if (reqcyc) begin
          wrEn  = 1'b1;
          beatD = lastBeat ? '0 : beatQ + 1'b1;
          if (lastBeat) stateD = IDLE;
        end
      end
      // The read is accepted at the edge that loads cnt; leaving on cnt==1 puts the
      // first beat on the bus exactly LATENCY cycles after acceptance.
      WAIT: begin
        cntD = cntQ - 1'b1;
        if (cntQ <= CNT_W'(1)) stateD = RDATA;
      end
      RDATA: begin
        if (respack) begin
          beatD = lastBeat ? '0 : beatQ + 1'b1;
          if (lastBeat) stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
    if (reset) reqack = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= IDLE;
      lineQ  <= '0;
      tagQ   <= '0;
      beatQ  <= '0;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      lineQ  <= lineD;
      tagQ   <= tagD;
      beatQ  <= beatD;
      cntQ   <= cntD;
    end
  end

  sysbus_line_store #(
    .DATA_WIDTH(DATA_WIDTH),
    .LINES     (LINES),
    .BEATS     (BEATS)
  ) u_store (
    .clk     (clk),
    .wrEn_i  (wrEn),
    .wrLine_i(lineQ),
    .wrBeat_i(beatQ),
    .wrData_i(req),
    .rdLine_i(lineQ),
    .rdBeat_i(beatQ),
    .rdData_o(rdData)
  );

  // Response outputs depend only on registered state, never on respack.
  assign respcyc = (stateQ == RDATA);
  assign resp    = respcyc ? rdData : '0;
  assign resptag = respcyc ? tagQ   : '0;

endmodule
